// File: rtl/reg_writeback_unit.sv
// Register-file write-side controller: merges fixed-latency ALU results with buffered
// memory results into a single registered write port and tracks pending destinations.
module reg_writeback_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic [ADDR_W-1:0]               issue_addr,
  input  logic                            alu_wb_valid,
  input  logic [ADDR_W-1:0]               alu_wb_addr,
  input  logic [DATA_W-1:0]               alu_wb_data,
  input  logic                            mem_wb_valid,
  output logic                            mem_wb_ready,
  input  logic [ADDR_W-1:0]               mem_wb_addr,
  input  logic [DATA_W-1:0]               mem_wb_data,
  output logic                            reg_wr,
  output logic [ADDR_W-1:0]               reg_wr_addr,
  output logic [DATA_W-1:0]               reg_wr_data,
  output logic [(2**ADDR_W)-1:0]          pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Memory-result buffer storage; no reset needed, occupancy is tracked by count_q.
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              alu_take;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign mem_wb_ready = reset && !fifo_full;
  assign push         = mem_wb_valid && mem_wb_ready;
  assign alu_take     = alu_wb_valid && (alu_wb_addr != '0);
  // Pop decision uses pre-edge occupancy, so a push into an empty buffer waits a cycle.
  assign pop          = !alu_take && !fifo_empty;
  assign head_addr    = fifo_addr_mem[rd_ptr_q];
  assign head_data    = fifo_data_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    reg_wr_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    if (alu_take) begin
      reg_wr_d      = 1'b1;
      reg_wr_addr_d = alu_wb_addr;
      reg_wr_data_d = alu_wb_data;
    end else if (pop && (head_addr != '0)) begin
      reg_wr_d      = 1'b1;
      reg_wr_addr_d = head_addr;
      reg_wr_data_d = head_data;
    end
  end

  // Per-register scoreboard bit: a new issue overrides a retirement on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_r0
        assign pend_d[gi] = 1'b0;
      end else begin : g_rn
        logic set_hit;
        logic clr_hit;
        assign set_hit    = issue_valid && (issue_addr == ADDR_W'(gi));
        assign clr_hit    = reg_wr_d && (reg_wr_addr_d == ADDR_W'(gi));
        assign pend_d[gi] = set_hit || (pend_q[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= mem_wb_addr;
      fifo_data_mem[wr_ptr_q] <= mem_wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      pend_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      pend_q        <= pend_d;
    end
  end

  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign pend_mask   = pend_q;
  assign fifo_count  = count_q;

endmodule
